// File: rtl/pool_row_sched.sv
// 2x2 max-pool row sequencer: even rows fold pixel pairs into a line buffer,
// odd rows fold vertically against it and emit POX/2 pooled pixels per beat.
module pool_row_sched #(
  parameter int POX           = 4,
  parameter int MAX_ROW_BEATS = 64,
  parameter int RB_W          = 8,
  parameter int ROW_W         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RB_W-1:0]   cfg_row_beats,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic              cfg_pool_en,
  input  logic [POX*16-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [POX*16-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int DW = POX * 16;
  localparam int HW = (POX / 2) * 16;
  localparam int AW = (MAX_ROW_BEATS > 1) ? $clog2(MAX_ROW_BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EVEN, S_ODD, S_DRAIN, S_PASS, S_FLUSH, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [RB_W-1:0]   rb_reg, col_reg, col_next;
  logic [ROW_W-1:0]  rows_reg, row_reg, rows_after;
  logic [HW-1:0]     linebuf [MAX_ROW_BEATS];
  logic [HW-1:0]     lb_rd_reg;
  logic [HW-1:0]     h_vec, pool_vec;
  logic [DW-1:0]     out_data_reg;
  logic              out_valid_reg;
  logic              accept, col_wrap, lb_we, start_ok;

  assign accept     = in_valid & in_ready;
  assign col_wrap   = (col_reg == rb_reg - 1'b1);
  assign rows_after = rows_reg - row_reg - 1'b1;
  assign start_ok   = (state_reg == S_IDLE) && start;
  assign lb_we      = accept && (state_reg == S_EVEN);

  // Per output pixel: horizontal pair max, then vertical max against the buffer.
  generate
    for (genvar gi = 0; gi < POX / 2; gi++) begin : g_px
      logic [15:0] px_a, px_b, h_max, lb_px;
      assign px_a  = in_data[32*gi +: 16];
      assign px_b  = in_data[32*gi+16 +: 16];
      assign h_max = (px_a >= px_b) ? px_a : px_b;
      assign lb_px = lb_rd_reg[16*gi +: 16];
      assign h_vec[16*gi +: 16]    = h_max;
      assign pool_vec[16*gi +: 16] = (h_max >= lb_px) ? h_max : lb_px;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (cfg_pool_en && cfg_rows >= ROW_W'(2) && cfg_row_beats != '0)
            state_next = S_EVEN;
          else if (!cfg_pool_en && cfg_rows != '0 && cfg_row_beats != '0)
            state_next = S_PASS;
          else
            state_next = S_DONE;
        end
      end
      S_EVEN:  if (accept && col_wrap) state_next = S_ODD;
      S_ODD: begin
        if (accept && col_wrap) begin
          if (rows_after >= ROW_W'(2))      state_next = S_EVEN;
          else if (rows_after == ROW_W'(1)) state_next = S_DRAIN;
          else                              state_next = S_FLUSH;
        end
      end
      S_DRAIN: if (accept && col_wrap) state_next = S_FLUSH;
      S_PASS:  if (accept && col_wrap && rows_after == '0) state_next = S_FLUSH;
      S_FLUSH: if (!out_valid_reg || out_ready) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    busy     = (state_reg != S_IDLE);
    done     = (state_reg == S_DONE);
    case (state_reg)
      S_EVEN, S_DRAIN: in_ready = 1'b1;
      S_ODD, S_PASS:   in_ready = !out_valid_reg || out_ready;
      default:         in_ready = 1'b0;
    endcase
  end

  always_comb begin
    col_next = col_reg;
    if (start_ok)      col_next = '0;
    else if (accept)   col_next = col_wrap ? '0 : col_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_reg   <= '0;
      rows_reg <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
    end else begin
      col_reg <= col_next;
      if (start_ok) begin
        rb_reg   <= cfg_row_beats;
        rows_reg <= cfg_rows;
        row_reg  <= '0;
      end else if (accept && col_wrap) begin
        row_reg <= row_reg + 1'b1;
      end
    end
  end

  // Read is prefetched at the next column so the ODD beat sees it registered;
  // a same-address write forwards (matters when a row is a single beat).
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[col_reg[AW-1:0]] <= h_vec;
    if (lb_we && col_reg == col_next) lb_rd_reg <= h_vec;
    else                              lb_rd_reg <= linebuf[col_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (accept && state_reg == S_ODD) begin
      out_data_reg  <= {{(DW-HW){1'b0}}, pool_vec};
      out_valid_reg <= 1'b1;
    end else if (accept && state_reg == S_PASS) begin
      out_data_reg  <= in_data;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: doc/pool_row_sched.md
Name: pool_row_sched

Overview:
- Sequencer for 2x2 max pooling on the post-processing output stream.
- Accepts POX-pixel beats row by row. In even rows it reduces each horizontal pixel pair and stores the maxima in an internal line buffer. In odd rows it takes the vertical max against the buffered value and emits POX/2 pooled pixels per beat.
- Sits between post-processing and the output writer.
- Also provides a bypass mode that forwards beats unpooled.
- Owns the row/column counting, start/done handshake and output backpressure.

Parameters:
- POX, 4, pixels per input beat; must be even and >= 2.
- MAX_ROW_BEATS, 64, line-buffer depth (maximum beats per row).
- RB_W, 8, width of cfg_row_beats.
- ROW_W, 10, width of cfg_rows.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; latches cfg_*; honoured only in IDLE.
- cfg_row_beats  in  RB_W  beats per row; legal range 1..MAX_ROW_BEATS.
- cfg_rows  in  ROW_W  rows in the feature map.
- cfg_pool_en  in  1  1 = 2x2 max pool, 0 = bypass.
- in_data  in  POX*16  pixels; pixel i is bits [16i+15:16i].
- in_valid  in  1  in_data valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_data  out  POX*16  pool mode: low POX/2*16 bits are pooled pixels, upper bits 0. Bypass: in_data copy.
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0 (in_ready, out_valid, out_data, busy, done); state IDLE; counters 0. Line-buffer contents are don't-care.
- Reset mid-job: job abandoned immediately; any held out_valid beat dropped.
- Config: cfg_* are latched on start in IDLE. They are ignored at all other times, and start is ignored while busy.
- Counters:
  - col counts 0..row_beats-1 and advances on each accepted input beat.
  - row advances when col wraps.
- States:
  - IDLE → EVEN on start, if pool_en=1 and rows>=2 and row_beats>=1.
  - IDLE → PASS on start, if pool_en=0 and rows>=1 and row_beats>=1.
  - IDLE → DONE on start, for any other config (empty job).
  - EVEN: in_ready=1. On each accepted beat, compute h[j] = max(px[2j], px[2j+1]) for j in 0..POX/2-1, and write the h vector to linebuf[col]. At col wrap → ODD.
  - ODD: in_ready = !out_valid | out_ready. On each accepted beat, compute h[j] as in EVEN, then out[j] = max(h[j], linebuf[col][j]). Register the result to out_data with out_valid=1 the next cycle (latency 1).
    - At col wrap with rows remaining >= 2 → EVEN.
    - At col wrap with exactly 1 row remaining (odd cfg_rows) → DRAIN.
    - At col wrap otherwise → FLUSH.
  - DRAIN: in_ready=1. Accept and discard one full row (row_beats beats), producing no output, then → FLUSH.
  - PASS: in_ready = !out_valid | out_ready. Each accepted beat is registered to out_data (latency 1). After rows*row_beats beats → FLUSH.
  - FLUSH: in_ready=0. Wait until out_valid=0, or out_valid & out_ready, then → DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then → IDLE.
- Comparisons are unsigned 16-bit. Ties select either operand, since the values are equal.
- Output register:
  - Sets out_valid on an accepted ODD/PASS beat.
  - Clears it on out_ready when no new beat is accepted.
  - Simultaneous accept and drain: the new data replaces the old and out_valid stays 1.
  - Throughput is 1 beat/cycle with out_ready held high.
- in_data is don't-care when in_valid=0. No input is consumed in IDLE/FLUSH/DONE.
- Output count per pooled job: floor(rows/2)*row_beats beats.

Test Plan:
- POX=4, row_beats=2, rows=2, pool. Row0 beats {1,5,3,2},{9,0,0,7}; row1 beats {4,4,8,1},{0,6,6,0}. Required outputs: {5,8}, then {9,7}; done pulses once; busy low afterwards.
- Same config, out_ready held 0 for 5 cycles after the first output. Required: out_valid and out_data held stable, in_ready=0 during the stall, no beats lost; done only after the second beat is accepted.
- Bypass, row_beats=3, rows=1, inputs 0x0001..0x0003 in pixel 0. Required: three identical output beats at 1-cycle latency, then done.
- Pool, rows=3, row_beats=1. Required: one output beat, the third row consumed with no output, done after the drain.
- Start with row_beats=0. Required: done one cycle later, no in_ready, no out_valid. A start pulse while busy is ignored (output count unchanged).
- Assert rst mid-ODD with out_valid=1. Required: next cycle out_valid=0, busy=0, state IDLE; a new job runs correctly.
